uart_rx_byte: RTL and testbench

//  UART 8N1 receiver; the receive-side counterpart of the team's uart_tx transmitter.

---
 rtl/uart_rx_byte.sv | 136 +++++++++++++
 tb/tb_uart_rx_byte.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: synchronises rx, finds the start bit, samples every bit at mid-period
// and presents each good byte with a one-cycle strobe; bad stop bits raise a framing-error strobe.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       led
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD - 1;
  localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = (BAUD_CNT_MAX > 0) ? $clog2(BAUD_CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_meta, rx_s, rx_s_d;
  logic             fall;
  logic             shift_en, bit_clr, good_byte, bad_byte;

  // Two-flop synchroniser; resets to the idle-high line level so reset release never looks like a start edge.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    good_byte = 1'b0;
    bad_byte  = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bit_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) begin
          state_n   = IDLE;
          good_byte = rx_s;
          bad_byte  = ~rx_s;
        end
      end
      default: state_n = IDLE;
    endcase

    // Counter restarts on every state change and wraps each bit period while in DATA.
    cnt_n = '0;
    if (state != IDLE && state_n == state) begin
      cnt_n = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      led        <= 1'b1;
    end else begin
      data_valid <= good_byte;
      frame_err  <= bad_byte;
      if (bit_clr) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx   <= bit_idx + 3'd1;
        shift_reg <= {rx_s, shift_reg[7:1]};
      end
      if (good_byte) begin
        data_out <= shift_reg;
        led      <= ~led;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLK_FREQ=960_000, BAUD=9600 (100 clk per bit);
// a negedge monitor records every strobe and the stimulus checks them against hand-computed bytes.
module tb_uart_rx_byte;

  localparam int BIT_CLKS = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic       led;

  int         n_checks = 0;
  int         n_pass   = 0;

  logic [7:0] rx_q[$];
  int         err_cycles = 0;
  int         pulse_viol = 0;
  logic       prev_pulse = 1'b0;
  logic       led_exp;

  uart_rx_byte #(
    .CLK_FREQ(960_000),
    .BAUD    (9600)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .led       (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) rx_q.push_back(data_out);
    if (frame_err) err_cycles++;
    if (data_valid && frame_err) pulse_viol++;
    if ((data_valid || frame_err) && prev_pulse) pulse_viol++;
    prev_pulse = data_valid || frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    rx = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bit_clks);
    end
    rx = stop_bit;
    wait_clks(bit_clks);
    rx = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    check({tag, " present"}, 32'(rx_q.size() > 0), 32'd1);
    if (rx_q.size() > 0) check(tag, 32'(rx_q.pop_front()), 32'(exp));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " data_out"}, 32'(data_out), 32'h00);
    check({tag, " data_valid"}, 32'(data_valid), 32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " led"}, 32'(led), 32'd1);
  endtask

  initial begin
    logic [7:0] v81;
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(5);
    check_reset_values("reset");
    rst = 1'b0;
    led_exp = 1'b1;
    wait_clks(20);

    // Single frame 0x55.
    send_byte(8'h55, 1'b1, BIT_CLKS);
    wait_clks(100);
    led_exp = ~led_exp;
    expect_byte("t1 byte", 8'h55);
    check("t1 extra bytes", 32'(rx_q.size()), 32'd0);
    check("t1 data_out", 32'(data_out), 32'h55);
    check("t1 led", 32'(led), 32'(led_exp));
    check("t1 frame_err", 32'(err_cycles), 32'd0);

    // Back-to-back frames, no idle gap.
    send_byte(8'hA3, 1'b1, BIT_CLKS);
    send_byte(8'h00, 1'b1, BIT_CLKS);
    send_byte(8'hFF, 1'b1, BIT_CLKS);
    wait_clks(100);
    led_exp = ~led_exp;
    led_exp = ~led_exp;
    led_exp = ~led_exp;
    expect_byte("t2 byte0", 8'hA3);
    expect_byte("t2 byte1", 8'h00);
    expect_byte("t2 byte2", 8'hFF);
    check("t2 extra bytes", 32'(rx_q.size()), 32'd0);
    check("t2 led", 32'(led), 32'(led_exp));
    check("t2 frame_err", 32'(err_cycles), 32'd0);

    // 20-clk glitch in IDLE is rejected at the half-bit sample.
    rx = 1'b0;
    wait_clks(10);
    check("t3 busy during glitch", 32'(busy), 32'd1);
    wait_clks(10);
    rx = 1'b1;
    wait_clks(40);
    check("t3 idle after glitch", 32'(busy), 32'd0);
    wait_clks(1100);
    check("t3 no byte", 32'(rx_q.size()), 32'd0);
    check("t3 no frame_err", 32'(err_cycles), 32'd0);

    // Bad stop bit: one frame_err cycle, data_out and led untouched.
    send_byte(8'h3C, 1'b0, BIT_CLKS);
    wait_clks(200);
    check("t4 frame_err cycles", 32'(err_cycles), 32'd1);
    check("t4 no byte", 32'(rx_q.size()), 32'd0);
    check("t4 data_out held", 32'(data_out), 32'hFF);
    check("t4 led held", 32'(led), 32'(led_exp));

    // Reset in the middle of bit 4 of 0x81, then a clean 0x7E.
    v81 = 8'h81;
    rx  = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = v81[i];
      wait_clks(BIT_CLKS);
    end
    rx = v81[4];
    wait_clks(50);
    check("t5 busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_clks(3);
    check_reset_values("t5 in rst");
    rx = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    led_exp = 1'b1;
    wait_clks(200);
    check("t5 no partial byte", 32'(rx_q.size()), 32'd0);
    send_byte(8'h7E, 1'b1, BIT_CLKS);
    wait_clks(100);
    led_exp = ~led_exp;
    expect_byte("t5 byte", 8'h7E);
    check("t5 led", 32'(led), 32'(led_exp));
    check("t5 frame_err", 32'(err_cycles), 32'd1);

    // Transmitter bit rate skewed +2% and -2%, back-to-back.
    send_byte(8'h96, 1'b1, 102);
    send_byte(8'h5A, 1'b1, 102);
    send_byte(8'h69, 1'b1, 98);
    send_byte(8'hC3, 1'b1, 98);
    wait_clks(150);
    expect_byte("t6 slow0", 8'h96);
    expect_byte("t6 slow1", 8'h5A);
    expect_byte("t6 fast0", 8'h69);
    expect_byte("t6 fast1", 8'hC3);
    check("t6 extra bytes", 32'(rx_q.size()), 32'd0);
    check("t6 frame_err", 32'(err_cycles), 32'd1);
    check("t6 data_out", 32'(data_out), 32'hC3);

    check("strobe exclusivity", 32'(pulse_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
